pipe_stage_skid: RTL and testbench



---
 rtl/pipe_stage_skid_pkg.sv | 27 ++
 rtl/pipe_stage_skid_dffl.sv | 18 +
 rtl/pipe_stage_skid.sv | 112 +++++++++++
 tb/tb_pipe_stage_skid.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the generic pipeline stage register: state encodings,
// the NOP instruction and per-stage payload packing widths/offsets.
package pipe_stage_skid_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  // IF/ID payload: {instaddr, inst}
  localparam int unsigned IFID_INST_LSB = 0;
  localparam int unsigned IFID_ADDR_LSB = 32;
  localparam int unsigned IFID_W        = 64;

  // ID/EX payload: {rd_addr, wen, op2, op1, instaddr, inst}
  localparam int unsigned IDEX_INST_LSB = 0;
  localparam int unsigned IDEX_ADDR_LSB = 32;
  localparam int unsigned IDEX_OP1_LSB  = 64;
  localparam int unsigned IDEX_OP2_LSB  = 96;
  localparam int unsigned IDEX_WEN_LSB  = 128;
  localparam int unsigned IDEX_RD_LSB   = 129;
  localparam int unsigned IDEX_W        = 134;

endpackage

// File: rtl/pipe_stage_skid_dffl.sv
// Parametrised-width flop with load enable and asynchronous active-high reset.
module gnrl_dffl_ar #(
  parameter int unsigned     DW      = 1,
  parameter logic [DW-1:0]   RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       qout <= RST_VAL;
    else if (lden) qout <= dnxt;
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline stage register with optional 2-entry skid buffer,
// ctrl hold, synchronous flush and NOP payload when empty.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned         DATA_W  = 96,
  parameter logic [DATA_W-1:0]   NOP_VAL = DATA_W'(INST_NOP),
  parameter int unsigned         SKID_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  input  logic              hold_i,
  input  logic              flush_i,
  output logic [1:0]        occ_o
);

  logic [1:0]        state_raw;
  state_t            state_q, state_nxt;
  logic [DATA_W-1:0] main_q, main_nxt, skid_q;
  logic              accept, rel, upd;

  assign state_q = state_t'(state_raw);
  assign occ_o   = state_raw;
  assign m_data  = main_q;
  assign m_valid = (state_q != ST_EMPTY) & ~hold_i;

  generate
    if (SKID_EN != 0) begin : g_sready_skid
      assign s_ready = (state_q != ST_TWO) & ~hold_i;
    end else begin : g_sready_pass
      assign s_ready = ((state_q == ST_EMPTY) | m_ready) & ~hold_i;
    end
  endgenerate

  // hold already gates s_ready/m_valid, so accept/rel are zero while held
  assign accept = s_valid & s_ready;
  assign rel    = m_valid & m_ready;
  assign upd    = flush_i | accept | rel;

  always_comb begin
    state_nxt = state_q;
    main_nxt  = main_q;
    if (flush_i) begin
      state_nxt = ST_EMPTY;
      main_nxt  = NOP_VAL;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) begin
          state_nxt = ST_ONE;
          main_nxt  = s_data;
        end
        ST_ONE: begin
          if (accept && rel) begin
            main_nxt = s_data;
          end else if (accept && (SKID_EN != 0)) begin
            state_nxt = ST_TWO;
          end else if (rel) begin
            state_nxt = ST_EMPTY;
            main_nxt  = NOP_VAL;
          end
        end
        ST_TWO: if (rel) begin
          state_nxt = ST_ONE;
          main_nxt  = skid_q;
        end
        default: begin
          state_nxt = ST_EMPTY;
          main_nxt  = NOP_VAL;
        end
      endcase
    end
  end

  gnrl_dffl_ar #(.DW(2), .RST_VAL(ST_EMPTY)) u_state (
    .clk(clk), .rst(rst), .lden(upd), .dnxt(state_nxt), .qout(state_raw)
  );

  gnrl_dffl_ar #(.DW(DATA_W), .RST_VAL(NOP_VAL)) u_main (
    .clk(clk), .rst(rst), .lden(upd), .dnxt(main_nxt), .qout(main_q)
  );

  generate
    if (SKID_EN != 0) begin : g_skid
      logic [DATA_W-1:0] skid_nxt;

      always_comb begin
        skid_nxt = skid_q;
        if (flush_i)
          skid_nxt = NOP_VAL;
        else if ((state_q == ST_ONE) && accept && !rel)
          skid_nxt = s_data;
        else if ((state_q == ST_TWO) && rel)
          skid_nxt = NOP_VAL;
      end

      gnrl_dffl_ar #(.DW(DATA_W), .RST_VAL(NOP_VAL)) u_skid (
        .clk(clk), .rst(rst), .lden(upd), .dnxt(skid_nxt), .qout(skid_q)
      );
    end else begin : g_noskid
      assign skid_q = NOP_VAL;
    end
  endgenerate

  occ_legal: assert property (@(posedge clk) disable iff (rst) occ_o != 2'd3);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid (skid and pass-through builds).
module tb_pipe_stage_skid;

  localparam int unsigned DW = 96;
  localparam logic [DW-1:0] NOP = 96'h13;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hold_i = 1'b0, flush_i = 1'b0;
  logic          s_valid = 1'b0, m_ready = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready, m_valid;
  logic [DW-1:0] m_data;
  logic [1:0]    occ_o;

  logic          n_s_valid = 1'b0, n_m_ready = 1'b0;
  logic [DW-1:0] n_s_data = '0;
  logic          n_s_ready, n_m_valid;
  logic [DW-1:0] n_m_data;
  logic [1:0]    n_occ;

  int unsigned n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .SKID_EN(1)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .hold_i(hold_i), .flush_i(flush_i), .occ_o(occ_o)
  );

  pipe_stage_skid #(.DATA_W(DW), .SKID_EN(0)) dut0 (
    .clk(clk), .rst(rst), .s_valid(n_s_valid), .s_ready(n_s_ready), .s_data(n_s_data),
    .m_valid(n_m_valid), .m_ready(n_m_ready), .m_data(n_m_data),
    .hold_i(hold_i), .flush_i(flush_i), .occ_o(n_occ)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    m_ready = 1'b0; s_valid = 1'b1;
    s_data = 96'hA1; tick();
    s_data = 96'hA2; tick();
    s_valid = 1'b0;
    n_cmp++; if (occ_o !== 2'd2) begin n_bad++; $display("FAIL reset_pre_occ got %0d want 2", occ_o); end
    #2 rst = 1'b1; #1;
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_mvalid got %b want 0", m_valid); end
    n_cmp++; if (m_data[31:0] !== 32'h13) begin n_bad++; $display("FAIL reset_mdata got %h want 00000013", m_data[31:0]); end
    n_cmp++; if (occ_o !== 2'd0) begin n_bad++; $display("FAIL reset_occ got %0d want 0", occ_o); end
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL reset_sready got %b want 1", s_ready); end
    tick(); rst = 1'b0; tick();
    n_cmp++; if (m_valid !== 1'b0 || occ_o !== 2'd0 || m_data !== NOP) begin
      n_bad++; $display("FAIL post_reset got v=%b occ=%0d d=%h want v=0 occ=0 d=%h", m_valid, occ_o, m_data, NOP);
    end
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_sready got %b want 1", s_ready); end
  endtask

  task automatic test_streaming();
    m_ready = 1'b1; s_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      s_data = DW'(i);
      tick();
      n_cmp++; if (m_data !== DW'(i) || m_valid !== 1'b1 || occ_o !== 2'd1) begin
        n_bad++; $display("FAIL stream_%0d got d=%h v=%b occ=%0d want d=%h v=1 occ=1", i, m_data, m_valid, occ_o, DW'(i));
      end
    end
    s_valid = 1'b0; tick();
    n_cmp++; if (occ_o !== 2'd0 || m_data !== NOP) begin
      n_bad++; $display("FAIL stream_drain got occ=%0d d=%h want occ=0 d=%h", occ_o, m_data, NOP);
    end
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0; s_valid = 1'b1;
    s_data = 96'hA; tick();
    s_data = 96'hB; tick();
    s_valid = 1'b0;
    n_cmp++; if (occ_o !== 2'd2 || s_ready !== 1'b0) begin
      n_bad++; $display("FAIL bp_full got occ=%0d rdy=%b want occ=2 rdy=0", occ_o, s_ready);
    end
    m_ready = 1'b1; #1;
    n_cmp++; if (m_data !== 96'hA || m_valid !== 1'b1) begin
      n_bad++; $display("FAIL bp_first got d=%h v=%b want d=a v=1", m_data, m_valid);
    end
    tick();
    n_cmp++; if (m_data !== 96'hB || occ_o !== 2'd1 || s_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_second got d=%h occ=%0d rdy=%b want d=b occ=1 rdy=1", m_data, occ_o, s_ready);
    end
    tick();
    n_cmp++; if (occ_o !== 2'd0 || m_data !== NOP || m_valid !== 1'b0) begin
      n_bad++; $display("FAIL bp_drain got occ=%0d d=%h v=%b want occ=0 d=%h v=0", occ_o, m_data, m_valid, NOP);
    end
  endtask

  task automatic test_hold();
    m_ready = 1'b1; s_valid = 1'b1; s_data = 96'hDEADBEEF; tick();
    hold_i = 1'b1; s_data = 96'h1111;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (m_valid !== 1'b0 || s_ready !== 1'b0 || m_data !== 96'hDEADBEEF || occ_o !== 2'd1) begin
        n_bad++; $display("FAIL hold_%0d got v=%b rdy=%b d=%h occ=%0d want v=0 rdy=0 d=deadbeef occ=1",
                          c, m_valid, s_ready, m_data, occ_o);
      end
      tick();
    end
    hold_i = 1'b0; s_valid = 1'b0; #1;
    n_cmp++; if (m_valid !== 1'b1 || m_data !== 96'hDEADBEEF) begin
      n_bad++; $display("FAIL hold_release got v=%b d=%h want v=1 d=deadbeef", m_valid, m_data);
    end
    tick();
    n_cmp++; if (occ_o !== 2'd0) begin n_bad++; $display("FAIL hold_drain got occ=%0d want 0", occ_o); end
  endtask

  task automatic test_flush_hold();
    m_ready = 1'b0; s_valid = 1'b1;
    s_data = 96'hC1; tick();
    s_data = 96'hC2; tick();
    flush_i = 1'b1; hold_i = 1'b1; s_data = 96'h55; tick();
    flush_i = 1'b0; hold_i = 1'b0; s_valid = 1'b0;
    n_cmp++; if (occ_o !== 2'd0 || m_data !== NOP || m_valid !== 1'b0) begin
      n_bad++; $display("FAIL flush got occ=%0d d=%h v=%b want occ=0 d=%h v=0", occ_o, m_data, m_valid, NOP);
    end
    m_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (m_valid !== 1'b0 || m_data === 96'h55) begin
        n_bad++; $display("FAIL flush_quiet_%0d got v=%b d=%h want v=0 d=%h", c, m_valid, m_data, NOP);
      end
    end
  endtask

  task automatic test_noskid();
    n_m_ready = 1'b0; n_s_valid = 1'b1; n_s_data = 96'hA; tick();
    n_cmp++; if (n_occ !== 2'd1 || n_m_data !== 96'hA) begin
      n_bad++; $display("FAIL noskid_load got occ=%0d d=%h want occ=1 d=a", n_occ, n_m_data);
    end
    n_s_data = 96'hC; #1;
    n_cmp++; if (n_s_ready !== 1'b0) begin n_bad++; $display("FAIL noskid_block got rdy=%b want 0", n_s_ready); end
    n_m_ready = 1'b1; #1;
    n_cmp++; if (n_s_ready !== 1'b1 || n_m_valid !== 1'b1) begin
      n_bad++; $display("FAIL noskid_pass got rdy=%b v=%b want rdy=1 v=1", n_s_ready, n_m_valid);
    end
    tick();
    n_cmp++; if (n_m_data !== 96'hC || n_occ !== 2'd1) begin
      n_bad++; $display("FAIL noskid_replace got d=%h occ=%0d want d=c occ=1", n_m_data, n_occ);
    end
    n_s_valid = 1'b0; tick();
    n_cmp++; if (n_occ !== 2'd0 || n_m_data !== NOP) begin
      n_bad++; $display("FAIL noskid_drain got occ=%0d d=%h want occ=0 d=%h", n_occ, n_m_data, NOP);
    end
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_streaming();
    test_backpressure();
    test_hold();
    test_flush_hold();
    test_noskid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
